// File: rtl/cronometro_multi_pkg.sv
// cronometro_multi_pkg: BCD digit limits, field offsets, packing width and run-state encoding
package cronometro_multi_pkg;
    localparam int BCD_W = 32;
    localparam logic [3:0] MAX9 = 4'd9;
    localparam logic [3:0] MAX5 = 4'd5;
    localparam int OFF_C0 = 0;
    localparam int OFF_C1 = 4;
    localparam int OFF_S0 = 8;
    localparam int OFF_S1 = 12;
    localparam int OFF_M0 = 16;
    localparam int OFF_M1 = 20;
    localparam int OFF_H0 = 24;
    localparam int OFF_H1 = 28;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
endpackage

// File: rtl/bcd_digit_updn.sv
// bcd_digit_updn: one BCD digit counting up or down over 0..MAXV with carry/borrow out
module bcd_digit_updn #(
    parameter logic [3:0] MAXV = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       step,
    input  logic       dir,
    output logic [3:0] digit,
    output logic       carry
);
    logic at_end;

    assign at_end = dir ? (digit == 4'd0) : (digit == MAXV);
    assign carry  = step && at_end;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            digit <= '0;
        else if (clr)
            digit <= '0;
        else if (load)
            digit <= (load_val > MAXV) ? MAXV : load_val;
        else if (step)
            digit <= at_end ? (dir ? MAXV : 4'd0) : (dir ? digit - 4'd1 : digit + 4'd1);
endmodule

// File: rtl/cronometro_multi.sv
// cronometro_multi: BCD stopwatch/timer with prescaler, clamped preset load and lap freeze
module cronometro_multi
    import cronometro_multi_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int HOUR_MAX = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             load,
    input  logic             mode,
    input  logic             lap,
    input  logic [BCD_W-1:0] preset,
    output logic [BCD_W-1:0] digits,
    output logic             running,
    output logic             done,
    output logic             lap_active
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] HMAX_BCD = to_bcd2(HOUR_MAX);
    localparam logic [6:0] HMAX7 = 7'(HOUR_MAX);
    localparam logic [BCD_W-1:0] TOP = {HMAX_BCD, MAX5, MAX9, MAX5, MAX9, MAX9, MAX9};

    state_t            state, state_nx;
    logic [PW-1:0]     pre;
    logic [BCD_W-1:0]  live, snap, ld_val;
    logic [8:0]        chain;
    logic [3:0]        h1c, h0c;
    logic [6:0]        hv;
    logic              tick, at_zero, hold, finish;

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign tick    = running && (pre == PW'(TICK_DIV - 1));
    assign at_zero = (live == '0);
    assign hold    = mode ? at_zero : (live == TOP);
    assign chain[0] = tick && !hold;
    // chain[8] can only rise if the hold compare were bypassed; it still ends the run
    assign finish  = (tick && (hold || (mode && live == 32'd1))) || chain[8];

    assign h1c    = (preset[OFF_H1+:4] > MAX9) ? MAX9 : preset[OFF_H1+:4];
    assign h0c    = (preset[OFF_H0+:4] > MAX9) ? MAX9 : preset[OFF_H0+:4];
    assign hv     = 7'(h1c) * 7'd10 + 7'(h0c);
    assign ld_val = (hv > HMAX7) ? {HMAX_BCD, preset[OFF_M1+3:0]} : preset;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_dig
            bcd_digit_updn #(.MAXV((4 * g == OFF_S1 || 4 * g == OFF_M1) ? MAX5 : MAX9)) u_dig (
                .clk      (clk),
                .reset    (reset),
                .clr      (clear),
                .load     (load),
                .load_val (ld_val[4*g+:4]),
                .step     (chain[g]),
                .dir      (mode),
                .digit    (live[4*g+:4]),
                .carry    (chain[g+1])
            );
        end
    endgenerate

    always_comb begin
        state_nx = (clear || load)                                      ? ST_IDLE :
                   finish                                               ? ST_DONE :
                   (start_stop && state == ST_RUN)                      ? ST_IDLE :
                   (start_stop && state == ST_IDLE && !(mode && at_zero)) ? ST_RUN  :
                                                                          state;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pre        <= '0;
            snap       <= '0;
            lap_active <= 1'b0;
        end else begin
            pre        <= (clear || load || tick) ? '0 : running ? pre + PW'(1) : pre;
            snap       <= (lap && !lap_active) ? live : snap;
            lap_active <= clear ? 1'b0 : lap ? !lap_active : lap_active;
        end

    assign digits = lap_active ? snap : live;
endmodule

// File: tb/tb_cronometro_multi.sv
// tb_cronometro_multi: vector table plus hand sequences, expectations queued and popped per check
module tb_cronometro_multi;
    logic        clk = 1'b0, reset = 1'b0;
    logic        start_stop = 1'b0, clear = 1'b0, load = 1'b0, mode = 1'b0, lap = 1'b0;
    logic [31:0] preset = '0, digits;
    logic        running, done, lap_active;

    always #5 clk = ~clk;

    cronometro_multi #(.TICK_DIV(2), .HOUR_MAX(99)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .mode       (mode),
        .lap        (lap),
        .preset     (preset),
        .digits     (digits),
        .running    (running),
        .done       (done),
        .lap_active (lap_active)
    );

    typedef enum int {OP_NONE, OP_CLEAR, OP_LOAD, OP_START, OP_LAP} op_t;
    typedef struct {
        op_t         op;
        logic [31:0] pre;
        logic        md;
        int          wait_n;
        logic [31:0] d;
        logic [2:0]  f;
    } vec_t;
    typedef struct {
        int          id;
        logic [31:0] d;
        logic [2:0]  f;
    } exp_t;

    localparam int NV = 28;
    vec_t vt[NV];
    exp_t sb[$];
    int   checks = 0, errors = 0;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] d, input logic [2:0] f);
        checks++;
        if (digits !== d) begin
            errors++;
            $display("FAIL %s digits got %h want %h", name, digits, d);
        end
        checks++;
        if ({running, done, lap_active} !== f) begin
            errors++;
            $display("FAIL %s flags{run,done,lap} got %b want %b", name, {running, done, lap_active}, f);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        mode       = v.md;
        preset     = v.pre;
        clear      = (v.op == OP_CLEAR);
        load       = (v.op == OP_LOAD);
        start_stop = (v.op == OP_START);
        lap        = (v.op == OP_LAP);
        sb.push_back('{id, v.d, v.f});
        if (v.op != OP_NONE) cyc(1);
        {clear, load, start_stop, lap} = 4'b0;
        cyc(v.wait_n);
        e = sb.pop_front();
        check($sformatf("vec%0d", e.id), e.d, e.f);
    endtask

    initial begin
        vt[0]  = '{OP_START, 32'h0,         1'b0, 20, 32'h0000_0010, 3'b100};
        vt[1]  = '{OP_CLEAR, 32'h0,         1'b0, 3,  32'h0000_0000, 3'b000};
        vt[2]  = '{OP_LOAD,  32'h0000_5999, 1'b0, 0,  32'h0000_5999, 3'b000};
        vt[3]  = '{OP_START, 32'h0,         1'b0, 2,  32'h0001_0000, 3'b100};
        vt[4]  = '{OP_LOAD,  32'h0059_5999, 1'b0, 0,  32'h0059_5999, 3'b000};
        vt[5]  = '{OP_START, 32'h0,         1'b0, 2,  32'h0100_0000, 3'b100};
        vt[6]  = '{OP_LOAD,  32'h9959_5999, 1'b0, 0,  32'h9959_5999, 3'b000};
        vt[7]  = '{OP_START, 32'h0,         1'b0, 2,  32'h9959_5999, 3'b010};
        vt[8]  = '{OP_START, 32'h0,         1'b0, 4,  32'h9959_5999, 3'b010};
        vt[9]  = '{OP_LOAD,  32'h0000_0003, 1'b1, 0,  32'h0000_0003, 3'b000};
        vt[10] = '{OP_START, 32'h0,         1'b1, 6,  32'h0000_0000, 3'b010};
        vt[11] = '{OP_START, 32'h0,         1'b1, 4,  32'h0000_0000, 3'b010};
        vt[12] = '{OP_CLEAR, 32'h0,         1'b1, 0,  32'h0000_0000, 3'b000};
        vt[13] = '{OP_START, 32'h0,         1'b1, 4,  32'h0000_0000, 3'b000};
        vt[14] = '{OP_LOAD,  32'h0100_0000, 1'b1, 0,  32'h0100_0000, 3'b000};
        vt[15] = '{OP_START, 32'h0,         1'b1, 2,  32'h0059_5999, 3'b100};
        vt[16] = '{OP_LOAD,  32'h0079_0000, 1'b0, 0,  32'h0059_0000, 3'b000};
        vt[17] = '{OP_LOAD,  32'hAB99_9999, 1'b0, 0,  32'h9959_5999, 3'b000};
        vt[18] = '{OP_LOAD,  32'h0000_0100, 1'b0, 0,  32'h0000_0100, 3'b000};
        vt[19] = '{OP_START, 32'h0,         1'b1, 2,  32'h0000_0099, 3'b100};
        vt[20] = '{OP_NONE,  32'h0,         1'b0, 2,  32'h0000_0100, 3'b100};
        vt[21] = '{OP_CLEAR, 32'h0,         1'b0, 0,  32'h0000_0000, 3'b000};
        vt[22] = '{OP_START, 32'h0,         1'b0, 24, 32'h0000_0012, 3'b100};
        vt[23] = '{OP_LAP,   32'h0,         1'b0, 0,  32'h0000_0012, 3'b101};
        vt[24] = '{OP_NONE,  32'h0,         1'b0, 9,  32'h0000_0012, 3'b101};
        vt[25] = '{OP_LAP,   32'h0,         1'b0, 0,  32'h0000_0017, 3'b100};
        vt[26] = '{OP_LAP,   32'h0,         1'b0, 0,  32'h0000_0017, 3'b101};
        vt[27] = '{OP_LAP,   32'h0,         1'b0, 0,  32'h0000_0018, 3'b100};

        cyc(2);
        check("in_reset", 32'h0, 3'b000);
        reset = 1'b1;
        cyc(2);
        check("after_reset", 32'h0, 3'b000);

        for (int i = 0; i < NV; i++) apply(vt[i], i);

        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        cyc(90);
        check("run_to_45", 32'h0000_0045, 3'b100);
        #2 reset = 1'b0;
        #1 check("async_reset", 32'h0, 3'b000);
        cyc(2);
        check("held_reset", 32'h0, 3'b000);
        reset = 1'b1;
        cyc(2);
        check("reset_release", 32'h0, 3'b000);
        preset = 32'h0079_0000;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("load_clamp", 32'h0059_0000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cronometro_multi.md
CRONOMETRO_MULTI -- requirements
Module: cronometro_multi

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per 1/100 s count step (>=1).
REQ-002 SHALL have parameter HOUR_MAX, default 99, maximum hour value (1..99), held as two BCD digits.
REQ-003 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_stop  in  1  one-cycle pulse, toggles running.
REQ-006 SHALL have port clear  in  1  one-cycle pulse, zero count, stop, clear flags.
REQ-007 SHALL have port load  in  1  one-cycle pulse, load preset digits, stop.
REQ-008 SHALL have port mode  in  1  0 = count up (stopwatch), 1 = count down (timer).
REQ-009 SHALL have port lap  in  1  one-cycle pulse, toggles display freeze.
REQ-010 SHALL have port preset  in  32  BCD {h1,h0,m1,m0,s1,s0,c1,c0}, 4 bits each, h1 in MSBs.
REQ-011 SHALL have port digits  out  32  displayed BCD, same packing as preset.
REQ-012 SHALL have ports running, done, lap_active  out  1 each  status flags.

Function
REQ-013 SHALL keep a prescaler counting 0..TICK_DIV-1 only while running; step pulse when prescaler = TICK_DIV-1, prescaler then wraps to 0.
REQ-014 SHALL apply one step to the live count per step pulse; live count visible on digits one cycle after the pulse edge.
REQ-015 Up mode: c0 0..9 carry into c1 0..9, s0 0..9, s1 0..5, m0 0..9, m1 0..5, hours 0..HOUR_MAX; all carries resolved in the same cycle (fully synchronous, no ripple clocks).
REQ-016 Up mode at HOUR_MAX:59:59.99: next step SHALL hold the count (no wrap), set done, clear running.
REQ-017 Down mode: borrow chain mirror of REQ-015; a step that reaches 00:00:00.00 SHALL set done and clear running in the same edge.
REQ-018 start_stop SHALL toggle running, except: ignored when done=1; ignored in down mode when count is all zero.
REQ-019 Priority on same cycle: clear > load > start_stop; lap is independent of all three.
REQ-020 clear SHALL set count 0, prescaler 0, running 0, done 0, lap_active 0.
REQ-021 load SHALL copy preset into count, prescaler 0, running 0, done 0; any digit above its legal maximum SHALL be clamped to that maximum (e.g. s1=7 -> 5); hours above HOUR_MAX clamp to HOUR_MAX.
REQ-022 lap pulse with lap_active=0 SHALL capture the live count into a snapshot register and set lap_active; with lap_active=1 SHALL clear lap_active.
REQ-023 digits SHALL show snapshot while lap_active=1, else live count; counting continues during lap.
REQ-024 lap coincident with a step pulse SHALL capture the pre-step value.
REQ-025 mode change while running SHALL take effect on the next step; no count change at switch.

Reset
REQ-026 reset low SHALL asynchronously force count, snapshot, prescaler to 0 and running, done, lap_active to 0; digits read 32'h0 during and after reset.
REQ-027 Release of reset SHALL be sampled synchronously; first step no earlier than TICK_DIV cycles after start_stop.

Structure
REQ-028 Shared include SHALL hold digit-limit constants (9, 5), BCD field offsets and the 32-bit packing width.
REQ-029 One sub-module, bcd_digit_updn: parameter MAXV, inputs step, dir, load value; outputs digit, carry/borrow-out; instantiated 8 times (hour pair handled with HOUR_MAX compare at top).
REQ-030 RTL SHALL contain no inferred latches and no derived clocks.

Verification (TICK_DIV=2)
REQ-031 Reset, start_stop, run 20 cycles -> digits = 32'h0000_0010, running=1.
REQ-032 load preset 32'h0000_5999, up, start, 2 cycles -> 32'h0001_0000 (s1/m0 carry).
REQ-033 load 32'h9959_5999 (HOUR_MAX=99), up, start, 2 cycles -> digits unchanged, done=1, running=0; start_stop ignored.
REQ-034 load 32'h0000_0003, mode=1, start, 6 cycles -> 32'h0, done=1; further start_stop ignored.
REQ-035 Running, lap at count 0x12 -> digits frozen 0x12 for 10 cycles while live advances; second lap -> digits show live 0x17.
REQ-036 Assert reset mid-run at count 0x45 -> digits 0, flags 0 immediately; load preset 32'h0079_0000 -> 32'h0059_0000 (clamped).
